// File: rtl/instr_fetch_unit.sv
// Multi-beat instruction fetch: reads INSTR_W/MEM_W consecutive memory words
// starting at a latched base address and packs them into one instruction word.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned MEM_W      = 8,
  parameter int unsigned INSTR_W    = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  mem_adr,
  output logic               mem_rd,
  input  logic [MEM_W-1:0]   mem_rdata,
  input  logic               mem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BEATS = INSTR_W / MEM_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               last_beat;
  int unsigned        lane;

  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  // Lane that the current beat fills, honouring the selected byte order.
  always_comb begin
    lane = 32'(beat_q);
    if (BIG_ENDIAN) begin
      lane = BEATS - 1 - 32'(beat_q);
    end
  end

  // Next-state logic: abort wins over everything, mem_valid only counts in FETCH.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    base_d        = base_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      StIdle: begin
        if (abort) begin
          instr_valid_d = 1'b0;
        end else if (fetch_start) begin
          base_d        = pc;
          beat_d        = '0;
          instr_d       = '0;
          instr_valid_d = 1'b0;
          state_d       = StFetch;
        end
      end
      StFetch: begin
        if (abort) begin
          // Partial lanes stay in instr; only the valid flag is dropped.
          beat_d        = '0;
          instr_valid_d = 1'b0;
          state_d       = StIdle;
        end else if (mem_valid) begin
          instr_d[lane*MEM_W +: MEM_W] = mem_rdata;
          if (last_beat) begin
            beat_d        = '0;
            instr_valid_d = 1'b1;
            state_d       = StDone;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        beat_d  = '0;
        state_d = StIdle;
        if (abort) begin
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      base_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    mem_rd      = (state_q == StFetch);
    busy        = (state_q == StFetch) || (state_q == StDone);
    done        = (state_q == StDone);
    mem_adr     = '0;
    if (state_q == StFetch) begin
      mem_adr = base_q + ADDR_W'(beat_q);
    end
    instr       = instr_q;
    instr_valid = instr_valid_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: little/big-endian byte fetch sharing one
// stimulus, plus a 16-bit-beat instance.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus for the 8-bit-beat instances.
  logic        fetch_start, abort, mem_valid;
  logic [7:0]  pc, mem_rdata;
  logic [7:0]  adr_le, adr_be;
  logic        rd_le, rd_be, iv_le, iv_be, busy_le, busy_be, done_le, done_be;
  logic [31:0] instr_le, instr_be;

  // 16-bit-beat instance.
  logic        fetch_start2, abort2, mem_valid2;
  logic [7:0]  pc2, adr2;
  logic [15:0] mem_rdata2;
  logic        rd2, iv2, busy2, done2;
  logic [31:0] instr2;

  logic [7:0]  mem   [256];
  logic [15:0] mem16 [256];

  assign mem_rdata  = mem[adr_le];
  assign mem_rdata2 = mem16[adr2];

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(.ADDR_W(8), .MEM_W(8), .INSTR_W(32), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .abort(abort), .pc(pc),
    .mem_adr(adr_le), .mem_rd(rd_le), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .instr(instr_le), .instr_valid(iv_le), .busy(busy_le), .done(done_le)
  );

  instr_fetch_unit #(.ADDR_W(8), .MEM_W(8), .INSTR_W(32), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .abort(abort), .pc(pc),
    .mem_adr(adr_be), .mem_rd(rd_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .instr(instr_be), .instr_valid(iv_be), .busy(busy_be), .done(done_be)
  );

  instr_fetch_unit #(.ADDR_W(8), .MEM_W(16), .INSTR_W(32), .BIG_ENDIAN(1'b0)) u_w16 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start2), .abort(abort2), .pc(pc2),
    .mem_adr(adr2), .mem_rd(rd2), .mem_rdata(mem_rdata2), .mem_valid(mem_valid2),
    .instr(instr2), .instr_valid(iv2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [7:0] addr);
    pc          = addr;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    pc          = 8'h00;
  endtask

  logic [7:0] wrap_adr [4];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i) ^ 8'h5A;
      mem16[i] = 16'h0000;
    end
    mem[8'h10] = 8'h20; mem[8'h11] = 8'h08; mem[8'h12] = 8'h43; mem[8'h13] = 8'h00;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    mem16[8'h40] = 16'hBEEF; mem16[8'h41] = 16'hDEAD;
    wrap_adr[0] = 8'hFE; wrap_adr[1] = 8'hFF; wrap_adr[2] = 8'h00; wrap_adr[3] = 8'h01;

    fetch_start = 1'b0; abort = 1'b0; mem_valid = 1'b0; pc = 8'h00;
    fetch_start2 = 1'b0; abort2 = 1'b0; mem_valid2 = 1'b0; pc2 = 8'h00;

    // Reset state.
    reset = 1'b1;
    #2;
    check("rst_outputs", {adr_le, 20'd0, rd_le, iv_le, busy_le, done_le}, 32'd0);
    check("rst_instr", instr_le, 32'd0);
    check("rst_w16", {adr2, 19'd0, rd2, iv2, busy2, done2, 1'b0}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1/2. Basic fetch, both byte orders, mem_valid tied high.
    mem_valid = 1'b1;
    start_fetch(8'h10);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("t1_rd_b%0d", b), {31'd0, rd_le & busy_le & ~done_le}, 32'd1);
      check($sformatf("t1_adr_b%0d", b), {24'd0, adr_le}, 32'h10 + 32'(b));
      tick();
    end
    check("t1_done", {31'd0, done_le}, 32'd1);
    check("t1_done_rd", {31'd0, rd_le}, 32'd0);
    check("t1_iv", {31'd0, iv_le}, 32'd1);
    check("t1_instr", instr_le, 32'h00430820);
    check("t2_instr_be", instr_be, 32'h20084300);
    tick();
    check("t1_done_pulse", {30'd0, done_le, busy_le}, 32'd0);
    check("t1_iv_hold", {31'd0, iv_le}, 32'd1);

    // 3. Address wrap.
    start_fetch(8'hFE);
    check("t3_iv_clr", {31'd0, iv_le}, 32'd0);
    check("t3_instr_clr", instr_le, 32'd0);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("t3_adr_b%0d", b), {24'd0, adr_le}, {24'd0, wrap_adr[b]});
      tick();
    end
    check("t3_instr", instr_le, 32'h44332211);
    tick();

    // 4. Stall before beat 2; fetch_start and pc changes while busy are ignored.
    start_fetch(8'h10);
    tick();
    tick();
    mem_valid   = 1'b0;
    fetch_start = 1'b1;
    pc          = 8'h80;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t4_stall_adr%0d", s), {24'd0, adr_le}, 32'h12);
      check($sformatf("t4_stall_done%0d", s), {31'd0, done_le}, 32'd0);
      tick();
    end
    fetch_start = 1'b0;
    mem_valid   = 1'b1;
    check("t4_resume_adr", {24'd0, adr_le}, 32'h12);
    tick();
    tick();
    check("t4_done", {31'd0, done_le}, 32'd1);
    check("t4_instr", instr_le, 32'h00430820);
    tick();

    // Abort in IDLE beats fetch_start and clears instr_valid.
    check("t4_iv_idle", {31'd0, iv_le}, 32'd1);
    abort       = 1'b1;
    fetch_start = 1'b1;
    pc          = 8'h10;
    tick();
    abort       = 1'b0;
    fetch_start = 1'b0;
    check("idle_abort_busy", {31'd0, busy_le}, 32'd0);
    check("idle_abort_iv", {31'd0, iv_le}, 32'd0);

    // 5. Abort after beat 1 with a coincident mem_valid.
    start_fetch(8'h10);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", {30'd0, busy_le, rd_le}, 32'd0);
    check("t5_iv", {31'd0, iv_le}, 32'd0);
    check("t5_instr", instr_le, 32'h00000820);
    tick();
    check("t5_stay_idle", {31'd0, busy_le}, 32'd0);

    // 6. Reset mid-fetch, not resumed.
    start_fetch(8'h10);
    tick();
    reset = 1'b1;
    #1;
    check("t6_rst_out", {adr_le, 20'd0, rd_le, iv_le, busy_le, done_le}, 32'd0);
    check("t6_rst_instr", instr_le, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_no_resume", {30'd0, busy_le, rd_le}, 32'd0);

    // 6b. 16-bit beats: two beats per instruction.
    mem_valid2   = 1'b1;
    pc2          = 8'h40;
    fetch_start2 = 1'b1;
    tick();
    fetch_start2 = 1'b0;
    pc2          = 8'h00;
    check("t6_w16_adr0", {24'd0, adr2}, 32'h40);
    tick();
    check("t6_w16_adr1", {24'd0, adr2}, 32'h41);
    check("t6_w16_notdone", {31'd0, done2}, 32'd0);
    tick();
    check("t6_w16_done", {30'd0, done2, iv2}, 32'd3);
    check("t6_w16_instr", instr2, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
